nexys_base_project_top: RTL and testbench
=========================================

Name: nexys_base_project_top

Overview:
Board-level top for the Nexys A7 base project. Provides a reusable I/O skeleton:
- synchronised switches mirrored on the LEDs;
- debounced push-buttons driving a 16-bit up/down counter;
- an 8-digit multiplexed seven-segment display.

All logic runs in one 100 MHz clock domain.

Parameters:
DEBOUNCE_CYCLES, 1_000_000, consecutive stable cycles before a debounced button level changes (10 ms at 100 MHz); minimum 2.
REFRESH_CYCLES, 100_000, cycles each seven-segment digit is enabled before advancing to the next; minimum 2.

Ports:
CLK  in  1  system clock, 100 MHz, all logic rising-edge.
RST  in  1  reset; asynchronous, active-high.
SW  in  16  slide switches, asynchronous to CLK.
BTNC/BTNU/BTND/BTNL/BTNR  in  1 each  push-buttons, active-high, asynchronous, bouncy.
LED  out  16  user LEDs, active-high.
AN  out  8  digit anodes, active-low one-hot.
SEG  out  7  segments {g,f,e,d,c,b,a}, active-low.
DP  out  1  decimal point, active-low.

Behaviour:
Reset:
- Every flop clears asynchronously on RST high.
- Reset values: LED=0, counter=0, debounced levels=0, digit index=0, refresh count=0, AN=8'hFE, SEG=7'h40 (glyph '0'), DP=1.

Input synchronisation:
- SW and all BTN inputs pass through 2-flop synchronisers before any use.

LED:
- LED is a registered copy of the synchronised SW.
- Latency from an SW change to LED is 3 CLK edges.

Debouncer (one per button):
- Each button has a stability counter.
- If the synchronised input differs from the debounced level, the counter increments; otherwise it clears.
- When the count reaches DEBOUNCE_CYCLES-1 while the input still differs, the debounced level takes the input value and the counter clears.
- Any glitch shorter than DEBOUNCE_CYCLES cycles is ignored.
- Each button has a 1-cycle rising-edge pulse on its debounced level.

Counter (16-bit), updated on edge pulses. Priority per cycle is C > L > R > U/D:
- C: clear to 0.
- L: load the synchronised SW.
- R: bitwise invert the counter.
- U alone: +1, wrapping FFFF->0000.
- D alone: -1, wrapping 0000->FFFF.
- U and D together: no change.

Display scan:
- The refresh counter counts 0..REFRESH_CYCLES-1.
- On the terminal count, the digit index increments mod 8.
- AN[i]=0 only for the current index.
- Digits 0-3 show counter nibbles [3:0],[7:4],[11:8],[15:12].
- Digits 4-7 show synchronised SW nibbles in the same order.
- SEG is the registered hex glyph for the selected nibble, aligned with AN in the same cycle.
- Glyphs (0-F) are 40,79,24,30,19,12,02,78,00,10,08,03,46,21,06,0E.
- DP is constantly 1.

Reset mid-operation:
- An RST pulse of any length immediately forces the reset values above.
- Button edges in progress are discarded.
- After release, a button already held high must still complete a full debounce before producing an edge.

Test Plan:
Use DEBOUNCE_CYCLES=4 and REFRESH_CYCLES=8 in all scenarios.
1. Hold RST 10 cycles, release on a clock edge -> LED=0, AN=FE, SEG=40, DP=1; no counter change for 100 cycles with buttons low.
2. SW=16'hA5C3 -> LED=A5C3 exactly 3 edges later; after a display sweep, AN=EF shows SEG=glyph(3)=30 and AN=7F shows glyph(A)=08.
3. BTNU clean press held 20 cycles -> counter=0001 (single increment). Then 3 bouncy BTND presses (2-cycle glitches followed by stable 20-cycle highs) -> counter 0001->0000->FFFF->FFFE.
4. Glitch BTNU high for 3 cycles then low -> counter unchanged.
5. BTNU and BTND asserted together -> counter unchanged. BTNC and BTNL together with SW=1234 -> counter=0000. BTNL alone -> 1234. BTNR -> EDCB.
6. Assert RST mid-scan, e.g. AN=DF and counter=0042 -> outputs return to reset values within the same cycle (asynchronous). After release, the scan restarts at digit 0 and counter=0000.

Source files
------------

// File: rtl/nexys_base_project_top_if.sv
// Board I/O bundle for the Nexys A7 base project: switches, buttons,
// LEDs and the multiplexed seven-segment display.
interface nexys_base_project_top_if;
    logic [15:0] SW;
    logic        BTNC;
    logic        BTNU;
    logic        BTND;
    logic        BTNL;
    logic        BTNR;
    logic [15:0] LED;
    logic [7:0]  AN;
    logic [6:0]  SEG;
    logic        DP;

    // Board side: drives switches/buttons, observes LEDs and display.
    modport master (
        output SW, BTNC, BTNU, BTND, BTNL, BTNR,
        input  LED, AN, SEG, DP
    );

    // Design side: samples switches/buttons, drives LEDs and display.
    modport slave (
        input  SW, BTNC, BTNU, BTND, BTNL, BTNR,
        output LED, AN, SEG, DP
    );
endinterface

// File: rtl/nexys_base_project_top.sv
// Nexys A7 base project top: switch-to-LED mirror, debounced buttons
// driving a 16-bit up/down counter, and an 8-digit hex display scan.
module nexys_base_project_top #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int REFRESH_CYCLES  = 100_000
) (
    input  logic                    CLK,
    input  logic                    RST,
    nexys_base_project_top_if.slave io
);
    localparam int DEB_W = $clog2(DEBOUNCE_CYCLES);
    localparam int REF_W = $clog2(REFRESH_CYCLES);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DEB_W-1:0] DEB_ONE  = DEB_W'(1);
    localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRESH_CYCLES - 1);
    localparam logic [REF_W-1:0] REF_ONE  = REF_W'(1);

    // Active-low seven-segment glyph {g,f,e,d,c,b,a} for a hex nibble.
    function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
        logic [6:0] g;
        case (nib)
            4'h0: g = 7'h40;
            4'h1: g = 7'h79;
            4'h2: g = 7'h24;
            4'h3: g = 7'h30;
            4'h4: g = 7'h19;
            4'h5: g = 7'h12;
            4'h6: g = 7'h02;
            4'h7: g = 7'h78;
            4'h8: g = 7'h00;
            4'h9: g = 7'h10;
            4'hA: g = 7'h08;
            4'hB: g = 7'h03;
            4'hC: g = 7'h46;
            4'hD: g = 7'h21;
            4'hE: g = 7'h06;
            4'hF: g = 7'h0E;
            default: g = 7'h7F;
        endcase
        return g;
    endfunction

    // Button vector order: 0=C, 1=U, 2=D, 3=L, 4=R.
    logic [4:0]  btn_raw_s;
    logic [4:0]  btn_meta_r;
    logic [4:0]  btn_sync_r;
    logic [15:0] sw_meta_r;
    logic [15:0] sw_sync_r;
    logic [15:0] led_r;
    logic [4:0]  deb_level_s;
    logic [4:0]  level_d_r;
    logic [4:0]  edge_s;
    logic [15:0] count_r;
    logic [15:0] cnt_next_s;
    logic [REF_W-1:0] refresh_r;
    logic [2:0]  digit_r;
    logic [2:0]  digit_next_s;
    logic [3:0]  nibble_s;
    logic [7:0]  an_r;
    logic [6:0]  seg_r;
    logic        dp_r;

    assign btn_raw_s = {io.BTNR, io.BTNL, io.BTND, io.BTNU, io.BTNC};

    // Two-flop synchronisers for switches and buttons, plus the LED mirror.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            btn_meta_r <= 5'b00000;
            btn_sync_r <= 5'b00000;
            sw_meta_r  <= 16'h0000;
            sw_sync_r  <= 16'h0000;
            led_r      <= 16'h0000;
        end else begin
            btn_meta_r <= btn_raw_s;
            btn_sync_r <= btn_meta_r;
            sw_meta_r  <= io.SW;
            sw_sync_r  <= sw_meta_r;
            led_r      <= sw_sync_r;
        end
    end

    for (genvar b = 0; b < 5; b++) begin : g_deb
        logic [DEB_W-1:0] cnt_r;
        logic             level_r;

        // Level only follows the input after DEBOUNCE_CYCLES consecutive differing cycles.
        always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
                cnt_r   <= {DEB_W{1'b0}};
                level_r <= 1'b0;
            end else if (btn_sync_r[b] != level_r) begin
                if (cnt_r == DEB_LAST) begin
                    level_r <= btn_sync_r[b];
                    cnt_r   <= {DEB_W{1'b0}};
                end else begin
                    cnt_r   <= cnt_r + DEB_ONE;
                end
            end else begin
                cnt_r <= {DEB_W{1'b0}};
            end
        end

        assign deb_level_s[b] = level_r;
    end

    // Delayed debounced levels for rising-edge detection.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            level_d_r <= 5'b00000;
        end else begin
            level_d_r <= deb_level_s;
        end
    end

    assign edge_s = deb_level_s & ~level_d_r;

    // Counter update with priority C > L > R > U/D; U and D together cancel.
    always_comb begin
        cnt_next_s = count_r;
        if (edge_s[0]) begin
            cnt_next_s = 16'h0000;
        end else if (edge_s[3]) begin
            cnt_next_s = sw_sync_r;
        end else if (edge_s[4]) begin
            cnt_next_s = ~count_r;
        end else if (edge_s[1] && !edge_s[2]) begin
            cnt_next_s = count_r + 16'h0001;
        end else if (edge_s[2] && !edge_s[1]) begin
            cnt_next_s = count_r - 16'h0001;
        end else begin
            cnt_next_s = count_r;
        end
    end

    // Counter register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            count_r <= 16'h0000;
        end else begin
            count_r <= cnt_next_s;
        end
    end

    // Digit index advances on the refresh terminal count; nibble follows the new index.
    always_comb begin
        digit_next_s = digit_r;
        if (refresh_r == REF_LAST) begin
            digit_next_s = digit_r + 3'd1;
        end else begin
            digit_next_s = digit_r;
        end
        case (digit_next_s)
            3'd0:    nibble_s = count_r[3:0];
            3'd1:    nibble_s = count_r[7:4];
            3'd2:    nibble_s = count_r[11:8];
            3'd3:    nibble_s = count_r[15:12];
            3'd4:    nibble_s = sw_sync_r[3:0];
            3'd5:    nibble_s = sw_sync_r[7:4];
            3'd6:    nibble_s = sw_sync_r[11:8];
            3'd7:    nibble_s = sw_sync_r[15:12];
            default: nibble_s = 4'h0;
        endcase
    end

    // Scan state and registered anode/segment outputs, kept in the same cycle.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            refresh_r <= {REF_W{1'b0}};
            digit_r   <= 3'd0;
            an_r      <= 8'hFE;
            seg_r     <= 7'h40;
            dp_r      <= 1'b1;
        end else begin
            refresh_r <= (refresh_r == REF_LAST) ? {REF_W{1'b0}} : refresh_r + REF_ONE;
            digit_r   <= digit_next_s;
            an_r      <= ~(8'h01 << digit_next_s);
            seg_r     <= hex_glyph(nibble_s);
            dp_r      <= 1'b1;
        end
    end

    assign io.LED = led_r;
    assign io.AN  = an_r;
    assign io.SEG = seg_r;
    assign io.DP  = dp_r;
endmodule

// File: tb/tb_nexys_base_project_top.sv
// Scoreboard bench for nexys_base_project_top: stimulus pushes expected
// observations into a queue, a negedge monitor pops and compares them.
module tb_nexys_base_project_top;
    logic clk;
    logic rst;
    int   total;
    int   bad;

    nexys_base_project_top_if intf();

    nexys_base_project_top #(
        .DEBOUNCE_CYCLES(4),
        .REFRESH_CYCLES (8)
    ) dut (
        .CLK(clk),
        .RST(rst),
        .io (intf)
    );

    typedef struct {
        string       name;
        int          sel;   // 0=LED, 1={AN,SEG}, 2=DP
        logic [15:0] exp;
    } item_t;

    item_t sb_q[$];

    logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: compare every pending expectation against the outputs on the falling edge.
    initial begin
        item_t       it;
        logic [15:0] act;
        forever begin
            @(negedge clk);
            while (sb_q.size() > 0) begin
                it = sb_q.pop_front();
                case (it.sel)
                    0:       act = intf.LED;
                    1:       act = {1'b0, intf.AN, intf.SEG};
                    2:       act = {15'd0, intf.DP};
                    default: act = 16'hFFFF;
                endcase
                total++;
                if (act !== it.exp) begin
                    bad++;
                    $display("FAIL %s: got %h expected %h", it.name, act, it.exp);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_item(input string name, input int sel, input logic [15:0] exp);
        item_t it;
        it.name = name;
        it.sel  = sel;
        it.exp  = exp;
        sb_q.push_back(it);
    endtask

    // Let the monitor consume the queue, then step to the next post-edge slot.
    task automatic drain();
        int guard;
        guard = 0;
        do begin
            @(negedge clk);
            #1;
            guard++;
        end while (sb_q.size() > 0 && guard < 4);
        if (sb_q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d items left, expected 0", sb_q.size());
            sb_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int sel, input logic [15:0] exp);
        expect_item(name, sel, exp);
        drain();
    endtask

    task automatic set_btn(input logic [4:0] v);
        intf.BTNC = v[0];
        intf.BTNU = v[1];
        intf.BTND = v[2];
        intf.BTNL = v[3];
        intf.BTNR = v[4];
    endtask

    // Hold the buttons in mask for hold cycles, release, wait for release debounce.
    task automatic press(input logic [4:0] mask, input int hold);
        set_btn(mask);
        tick(hold);
        set_btn(5'b00000);
        tick(20);
    endtask

    // Wait (bounded) until digit d is selected, then expect its glyph there.
    task automatic check_digit(input string name, input int d, input logic [6:0] g);
        logic [7:0] an_exp;
        int         n;
        an_exp = ~(8'h01 << d);
        n = 0;
        while (intf.AN !== an_exp && n < 100) begin
            tick(1);
            n++;
        end
        if (intf.AN !== an_exp) begin
            total++;
            bad++;
            $display("FAIL %s: anode %h never seen, last %h", name, an_exp, intf.AN);
        end else begin
            chk(name, 1, {1'b0, an_exp, g});
        end
    endtask

    task automatic check_counter(input string name, input logic [15:0] v);
        for (int d = 0; d < 4; d++) begin
            check_digit(name, d, glyph[v[d*4 +: 4]]);
        end
    endtask

    // Global watchdog.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        intf.SW = 16'h0000;
        set_btn(5'b00000);

        // 1. Reset state and idle counter.
        tick(10);
        expect_item("rst_led", 0, 16'h0000);
        expect_item("rst_anseg", 1, {1'b0, 8'hFE, 7'h40});
        expect_item("rst_dp", 2, 16'h0001);
        drain();
        rst = 1'b0;
        chk("post_rst_anseg", 1, {1'b0, 8'hFE, 7'h40});
        tick(100);
        check_counter("idle_cnt", 16'h0000);

        // 2. LED latency and switch digits.
        intf.SW = 16'hA5C3;
        tick(2);
        chk("led_edge2", 0, 16'h0000);
        chk("led_edge3", 0, 16'hA5C3);
        check_digit("sw_dig4", 4, 7'h30);
        check_digit("sw_dig7", 7, 7'h08);

        // 3. Clean up press, then three bouncy down presses.
        press(5'b00010, 20);
        check_counter("up1", 16'h0001);
        for (int k = 0; k < 3; k++) begin
            set_btn(5'b00100);
            tick(2);
            set_btn(5'b00000);
            tick(2);
            press(5'b00100, 20);
            case (k)
                0:       check_counter("dn1", 16'h0000);
                1:       check_counter("dn2", 16'hFFFF);
                default: check_counter("dn3", 16'hFFFE);
            endcase
        end

        // 4. Short glitch ignored.
        press(5'b00010, 3);
        check_counter("glitch", 16'hFFFE);

        // 5. U+D cancel, C beats L, L loads, R inverts.
        press(5'b00110, 20);
        check_counter("u_and_d", 16'hFFFE);
        intf.SW = 16'h1234;
        press(5'b01001, 20);
        check_counter("c_over_l", 16'h0000);
        press(5'b01000, 20);
        check_counter("load", 16'h1234);
        press(5'b10000, 20);
        check_counter("invert", 16'hEDCB);

        // 6. Asynchronous reset mid-scan.
        intf.SW = 16'h0042;
        press(5'b01000, 20);
        check_counter("load42", 16'h0042);
        check_digit("pre_rst_dig5", 5, glyph[4'h4]);
        tick(1);
        rst = 1'b1;
        expect_item("mid_rst_led", 0, 16'h0000);
        expect_item("mid_rst_anseg", 1, {1'b0, 8'hFE, 7'h40});
        expect_item("mid_rst_dp", 2, 16'h0001);
        drain();
        rst = 1'b0;
        chk("scan_restart", 1, {1'b0, 8'hFE, 7'h40});
        check_counter("cnt_after_rst", 16'h0000);

        // Button held across reset must re-debounce and count exactly once.
        set_btn(5'b00010);
        tick(2);
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(30);
        check_counter("held_thru_rst", 16'h0001);
        set_btn(5'b00000);
        tick(20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
